// File: rtl/terminate_rs_if.sv
// Bundle between dispatch/writeback, the terminate reservation station and the terminate pipeline.
// Signal names match the station's external port list one-to-one.
interface terminate_rs_if #(
  parameter int DEPTH = 4
);
  // Issue handshake: a transfer happens on a cycle where instr_valid and instr_ready are both 1.
  // While instr_valid is 1 and instr_ready is 0, the issued fields hold steady (unless flushed).
  logic                         flush;
  logic                         disp_valid;
  logic                         disp_ready;
  logic [3:0]                   disp_opcode;
  logic [7:0]                   disp_offset;
  logic [3:0]                   disp_immediate;
  logic [4:0]                   disp_rob_entry;
  logic [7:0]                   disp_arch_dest_regs;
  logic [9:0]                   disp_phys_dest_regs;
  logic [4:0]                   disp_base_tag;
  logic                         disp_base_rdy;
  logic [15:0]                  disp_base_val;
  logic [4:0]                   disp_flag_tag;
  logic                         disp_flag_rdy;
  logic [7:0]                   disp_flag_val;
  logic                         wb_valid;
  logic [4:0]                   wb_tag;
  logic [15:0]                  wb_value;
  logic [3:0]                   opcode;
  logic [15:0]                  reg_base_val;
  logic [7:0]                   flag_vals;
  logic [7:0]                   offset;
  logic [3:0]                   immediate;
  logic                         instr_valid;
  logic                         instr_ready;
  logic [4:0]                   ROB_entries;
  logic [7:0]                   arch_dest_regs;
  logic [9:0]                   phys_dest_regs;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;

  modport master (
    output flush, disp_valid, disp_opcode, disp_offset, disp_immediate, disp_rob_entry,
           disp_arch_dest_regs, disp_phys_dest_regs, disp_base_tag, disp_base_rdy,
           disp_base_val, disp_flag_tag, disp_flag_rdy, disp_flag_val,
           wb_valid, wb_tag, wb_value, instr_ready,
    input  disp_ready, opcode, reg_base_val, flag_vals, offset, immediate, instr_valid,
           ROB_entries, arch_dest_regs, phys_dest_regs, occupancy
  );

  modport slave (
    input  flush, disp_valid, disp_opcode, disp_offset, disp_immediate, disp_rob_entry,
           disp_arch_dest_regs, disp_phys_dest_regs, disp_base_tag, disp_base_rdy,
           disp_base_val, disp_flag_tag, disp_flag_rdy, disp_flag_val,
           wb_valid, wb_tag, wb_value, instr_ready,
    output disp_ready, opcode, reg_base_val, flag_vals, offset, immediate, instr_valid,
           ROB_entries, arch_dest_regs, phys_dest_regs, occupancy
  );
endinterface

// File: rtl/terminate_rs.sv
// Reservation station for jump/branch ops: collapsing age-ordered queue (slot 0 oldest),
// operand capture from the writeback broadcast, oldest-ready issue.
module terminate_rs #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  terminate_rs_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic        valid;
    logic [3:0]  opcode;
    logic [7:0]  offset;
    logic [3:0]  immediate;
    logic [4:0]  rob;
    logic [7:0]  arch;
    logic [9:0]  phys;
    logic        base_rdy;
    logic [4:0]  base_tag;
    logic [15:0] base_val;
    logic        flag_rdy;
    logic [4:0]  flag_tag;
    logic [7:0]  flag_val;
  } entry_t;

  entry_t           slot_q [DEPTH];
  entry_t           slot_d [DEPTH];
  entry_t           woken_ext [DEPTH+1];
  entry_t           new_e;
  entry_t           sel_e;
  logic [OCC_W-1:0] occ_q, occ_d, sel_idx, wr_pos, lock_idx_q, lock_idx_d;
  logic             lock_q, lock_d;
  logic             found, issue, enq;

  // A stalled issue stays pinned to its slot so an older entry waking up cannot swap the outputs.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    if (lock_q) begin
      found   = 1'b1;
      sel_idx = lock_idx_q;
    end else begin
      for (int i = DEPTH-1; i >= 0; i--) begin
        if (slot_q[i].valid && slot_q[i].base_rdy && slot_q[i].flag_rdy) begin
          found   = 1'b1;
          sel_idx = OCC_W'(i);
        end
      end
    end
    sel_e = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (found && OCC_W'(i) == sel_idx) sel_e = slot_q[i];
    end
  end

  assign bus.instr_valid    = found;
  assign bus.opcode         = sel_e.opcode;
  assign bus.reg_base_val   = sel_e.base_val;
  assign bus.flag_vals      = sel_e.flag_val;
  assign bus.offset         = sel_e.offset;
  assign bus.immediate      = sel_e.immediate;
  assign bus.ROB_entries    = sel_e.rob;
  assign bus.arch_dest_regs = sel_e.arch;
  assign bus.phys_dest_regs = sel_e.phys;
  assign bus.occupancy      = occ_q;
  assign bus.disp_ready     = (occ_q < OCC_W'(DEPTH));

  assign issue  = found & bus.instr_ready;
  assign enq    = bus.disp_valid & bus.disp_ready;
  assign wr_pos = occ_q - OCC_W'(issue);

  always_comb begin
    new_e           = '0;
    new_e.valid     = 1'b1;
    new_e.opcode    = bus.disp_opcode;
    new_e.offset    = bus.disp_offset;
    new_e.immediate = bus.disp_immediate;
    new_e.rob       = bus.disp_rob_entry;
    new_e.arch      = bus.disp_arch_dest_regs;
    new_e.phys      = bus.disp_phys_dest_regs;
    new_e.base_tag  = bus.disp_base_tag;
    new_e.base_rdy  = bus.disp_base_rdy;
    new_e.base_val  = bus.disp_base_val;
    new_e.flag_tag  = bus.disp_flag_tag;
    new_e.flag_rdy  = bus.disp_flag_rdy;
    new_e.flag_val  = bus.disp_flag_val;
    // Same-cycle broadcast of a source the dispatcher still sees as pending.
    if (!bus.disp_base_rdy && bus.wb_valid && bus.wb_tag == bus.disp_base_tag) begin
      new_e.base_rdy = 1'b1;
      new_e.base_val = bus.wb_value;
    end
    if (!bus.disp_flag_rdy && bus.wb_valid && bus.wb_tag == bus.disp_flag_tag) begin
      new_e.flag_rdy = 1'b1;
      new_e.flag_val = bus.wb_value[7:0];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken_ext[i] = slot_q[i];
      if (slot_q[i].valid && !slot_q[i].base_rdy && bus.wb_valid &&
          bus.wb_tag == slot_q[i].base_tag) begin
        woken_ext[i].base_rdy = 1'b1;
        woken_ext[i].base_val = bus.wb_value;
      end
      if (slot_q[i].valid && !slot_q[i].flag_rdy && bus.wb_valid &&
          bus.wb_tag == slot_q[i].flag_tag) begin
        woken_ext[i].flag_rdy = 1'b1;
        woken_ext[i].flag_val = bus.wb_value[7:0];
      end
    end
    woken_ext[DEPTH] = '0;
  end

  // Collapse over the issued slot, then drop the new entry just past the surviving ones.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_d[i] = woken_ext[i];
      if (issue && OCC_W'(i) >= sel_idx) slot_d[i] = woken_ext[i+1];
      if (enq && OCC_W'(i) == wr_pos) slot_d[i] = new_e;
    end
    occ_d      = occ_q + OCC_W'(enq) - OCC_W'(issue);
    lock_d     = found & ~bus.instr_ready;
    lock_idx_d = sel_idx;
    if (bus.flush) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
      occ_d  = '0;
      lock_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      occ_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      occ_q      <= occ_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
endmodule

// File: tb/tb_terminate_rs.sv
// Directed bench for terminate_rs: hand-computed expectations for dispatch, wakeup,
// bypass, ordering, stall stability, flush and asynchronous reset.
module tb_terminate_rs;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  terminate_rs_if #(.DEPTH(4)) bus ();

  terminate_rs #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    bus.wb_valid = 1'b0;
    bus.wb_tag = '0;
    bus.wb_value = '0;
    bus.disp_opcode = '0;
    bus.disp_offset = '0;
    bus.disp_immediate = '0;
    bus.disp_rob_entry = '0;
    bus.disp_arch_dest_regs = '0;
    bus.disp_phys_dest_regs = '0;
    bus.disp_base_tag = '0;
    bus.disp_base_rdy = 1'b0;
    bus.disp_base_val = '0;
    bus.disp_flag_tag = '0;
    bus.disp_flag_rdy = 1'b0;
    bus.disp_flag_val = '0;
  endtask

  // Payload fields are derived from op/rob so issued values can be checked by hand.
  task automatic set_disp(input logic [3:0] op, input logic [4:0] rob,
                          input logic [4:0] btag, input logic brdy, input logic [15:0] bval,
                          input logic [4:0] ftag, input logic frdy, input logic [7:0] fval);
    bus.disp_valid = 1'b1;
    bus.disp_opcode = op;
    bus.disp_offset = {3'b000, rob} + 8'h40;
    bus.disp_immediate = op ^ 4'hA;
    bus.disp_rob_entry = rob;
    bus.disp_arch_dest_regs = {op, 4'h3};
    bus.disp_phys_dest_regs = {rob, 5'd1};
    bus.disp_base_tag = btag;
    bus.disp_base_rdy = brdy;
    bus.disp_base_val = bval;
    bus.disp_flag_tag = ftag;
    bus.disp_flag_rdy = frdy;
    bus.disp_flag_val = fval;
  endtask

  task automatic wb(input logic [4:0] tag, input logic [15:0] val);
    bus.wb_valid = 1'b1;
    bus.wb_tag = tag;
    bus.wb_value = val;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    idle();
    bus.instr_ready = 1'b0;
    #1;
    check("rst_occ", 32'(bus.occupancy), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_disp_ready", 32'(bus.disp_ready), 1);
    check("rst_base", 32'(bus.reg_base_val), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single ready op
    bus.instr_ready = 1'b1;
    set_disp(4'h1, 5'd7, 5'd0, 1'b1, 16'h1234, 5'd0, 1'b1, 8'h05);
    #1;
    check("t1_pre_valid", 32'(bus.instr_valid), 0);
    tick();
    bus.disp_valid = 1'b0;
    check("t1_valid", 32'(bus.instr_valid), 1);
    check("t1_opcode", 32'(bus.opcode), 32'h1);
    check("t1_base", 32'(bus.reg_base_val), 32'h1234);
    check("t1_flags", 32'(bus.flag_vals), 32'h05);
    check("t1_rob", 32'(bus.ROB_entries), 7);
    check("t1_offset", 32'(bus.offset), 32'h47);
    check("t1_imm", 32'(bus.immediate), 32'hB);
    check("t1_arch", 32'(bus.arch_dest_regs), 32'h13);
    check("t1_phys", 32'(bus.phys_dest_regs), 32'h0E1);
    check("t1_occ", 32'(bus.occupancy), 1);
    tick();
    check("t1_occ_after", 32'(bus.occupancy), 0);
    check("t1_valid_after", 32'(bus.instr_valid), 0);
    check("t1_base_zero", 32'(bus.reg_base_val), 0);

    // Wakeup of a pending base operand
    set_disp(4'h2, 5'd3, 5'd9, 1'b0, 16'h0000, 5'd0, 1'b1, 8'h11);
    tick();
    bus.disp_valid = 1'b0;
    check("t2_wait0", 32'(bus.instr_valid), 0);
    check("t2_occ", 32'(bus.occupancy), 1);
    tick();
    check("t2_wait1", 32'(bus.instr_valid), 0);
    wb(5'd9, 16'hBEEF);
    #1;
    check("t2_wb_cycle", 32'(bus.instr_valid), 0);
    tick();
    bus.wb_valid = 1'b0;
    check("t2_valid", 32'(bus.instr_valid), 1);
    check("t2_base", 32'(bus.reg_base_val), 32'hBEEF);
    check("t2_flags", 32'(bus.flag_vals), 32'h11);
    check("t2_rob", 32'(bus.ROB_entries), 3);
    tick();
    check("t2_occ_after", 32'(bus.occupancy), 0);

    // Younger ready op overtakes an older waiting one; one wb wakes both operands
    set_disp(4'h3, 5'd1, 5'd3, 1'b0, 16'h0000, 5'd3, 1'b0, 8'h00);
    tick();
    set_disp(4'h4, 5'd2, 5'd4, 1'b1, 16'h2222, 5'd4, 1'b1, 8'h22);
    tick();
    bus.disp_valid = 1'b0;
    check("t3_b_valid", 32'(bus.instr_valid), 1);
    check("t3_b_rob", 32'(bus.ROB_entries), 2);
    check("t3_occ2", 32'(bus.occupancy), 2);
    tick();
    check("t3_a_wait", 32'(bus.instr_valid), 0);
    check("t3_occ1", 32'(bus.occupancy), 1);
    wb(5'd3, 16'h3333);
    tick();
    bus.wb_valid = 1'b0;
    check("t3_a_valid", 32'(bus.instr_valid), 1);
    check("t3_a_rob", 32'(bus.ROB_entries), 1);
    check("t3_a_base", 32'(bus.reg_base_val), 32'h3333);
    check("t3_a_flags", 32'(bus.flag_vals), 32'h33);
    tick();
    check("t3_occ0", 32'(bus.occupancy), 0);

    // Fill, stall, in-order drain with an enqueue during issue
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(4'h5, 5'(10 + k), 5'd0, 1'b1, 16'h1000 + 16'(k), 5'd0, 1'b1, 8'h10 + 8'(k));
      tick();
      check("t4_fill_occ", 32'(bus.occupancy), 32'(k + 1));
    end
    bus.disp_valid = 1'b0;
    check("t4_full_ready", 32'(bus.disp_ready), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t4_hold_rob", 32'(bus.ROB_entries), 10);
      check("t4_hold_base", 32'(bus.reg_base_val), 32'h1000);
    end
    bus.instr_ready = 1'b1;
    tick();
    check("t4_rob11", 32'(bus.ROB_entries), 11);
    check("t4_occ3", 32'(bus.occupancy), 3);
    check("t4_ready_again", 32'(bus.disp_ready), 1);
    set_disp(4'h5, 5'd14, 5'd0, 1'b1, 16'h1004, 5'd0, 1'b1, 8'h14);
    tick();
    bus.disp_valid = 1'b0;
    check("t4_enq_issue_occ", 32'(bus.occupancy), 3);
    check("t4_rob12", 32'(bus.ROB_entries), 12);
    tick();
    check("t4_rob13", 32'(bus.ROB_entries), 13);
    tick();
    check("t4_rob14", 32'(bus.ROB_entries), 14);
    check("t4_base14", 32'(bus.reg_base_val), 32'h1004);
    tick();
    check("t4_empty", 32'(bus.instr_valid), 0);

    // Stalled issue stays on its slot even when an older entry wakes
    bus.instr_ready = 1'b0;
    set_disp(4'h6, 5'd20, 5'd8, 1'b0, 16'h0000, 5'd0, 1'b1, 8'h20);
    tick();
    set_disp(4'h6, 5'd21, 5'd0, 1'b1, 16'h2121, 5'd0, 1'b1, 8'h21);
    tick();
    bus.disp_valid = 1'b0;
    check("t5_sel21", 32'(bus.ROB_entries), 21);
    wb(5'd8, 16'h0808);
    tick();
    bus.wb_valid = 1'b0;
    check("t5_lock_rob", 32'(bus.ROB_entries), 21);
    check("t5_lock_base", 32'(bus.reg_base_val), 32'h2121);
    bus.instr_ready = 1'b1;
    tick();
    check("t5_rob20", 32'(bus.ROB_entries), 20);
    check("t5_base20", 32'(bus.reg_base_val), 32'h0808);
    tick();
    check("t5_occ0", 32'(bus.occupancy), 0);

    // Enqueue bypass from a same-cycle broadcast
    set_disp(4'h7, 5'd5, 5'd6, 1'b0, 16'h0000, 5'd0, 1'b1, 8'h55);
    wb(5'd6, 16'h00A0);
    tick();
    bus.disp_valid = 1'b0;
    bus.wb_valid = 1'b0;
    check("t6_valid", 32'(bus.instr_valid), 1);
    check("t6_base", 32'(bus.reg_base_val), 32'h00A0);
    check("t6_rob", 32'(bus.ROB_entries), 5);
    tick();
    check("t6_occ0", 32'(bus.occupancy), 0);

    // Flush a full station, then flush one that would accept a dispatch
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_disp(4'h8, 5'(24 + k), 5'd0, 1'b1, 16'h4000 + 16'(k), 5'd0, 1'b1, 8'h40);
      tick();
    end
    check("t7_full", 32'(bus.occupancy), 4);
    bus.flush = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    check("t7_valid_in_flush", 32'(bus.instr_valid), 1);
    tick();
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    check("t7_occ", 32'(bus.occupancy), 0);
    check("t7_valid", 32'(bus.instr_valid), 0);
    check("t7_disp_ready", 32'(bus.disp_ready), 1);
    bus.instr_ready = 1'b0;
    set_disp(4'h8, 5'd28, 5'd0, 1'b1, 16'h4444, 5'd0, 1'b1, 8'h44);
    tick();
    bus.flush = 1'b1;
    set_disp(4'h8, 5'd29, 5'd0, 1'b1, 16'h4545, 5'd0, 1'b1, 8'h45);
    tick();
    bus.flush = 1'b0;
    bus.disp_valid = 1'b0;
    check("t7_drop_occ", 32'(bus.occupancy), 0);
    check("t7_drop_valid", 32'(bus.instr_valid), 0);

    // Asynchronous reset mid-stream
    set_disp(4'h9, 5'd30, 5'd0, 1'b1, 16'h3030, 5'd0, 1'b1, 8'h30);
    tick();
    set_disp(4'h9, 5'd31, 5'd0, 1'b1, 16'h3131, 5'd0, 1'b1, 8'h31);
    tick();
    bus.disp_valid = 1'b0;
    check("t8_pre_occ", 32'(bus.occupancy), 2);
    check("t8_pre_valid", 32'(bus.instr_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t8_rst_valid", 32'(bus.instr_valid), 0);
    check("t8_rst_occ", 32'(bus.occupancy), 0);
    check("t8_rst_base", 32'(bus.reg_base_val), 0);
    check("t8_rst_rob", 32'(bus.ROB_entries), 0);
    check("t8_rst_disp_ready", 32'(bus.disp_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("t8_post_occ", 32'(bus.occupancy), 0);
    check("t8_post_valid", 32'(bus.instr_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/terminate_rs.md
Name: terminate_rs

Overview:
Reservation station for terminate-class (jump/branch) instructions, directly upstream of the terminate pipeline. Holds dispatched jump/branch ops until the base-address register and flag register operands are both available, capturing them from the writeback broadcast. Issues the oldest ready entry per cycle over a valid/ready handshake. Output ports are named to connect one-to-one with the terminate pipeline inputs.

Parameters:
DEPTH, 4, number of entries (2..16); occupancy width is clog2(DEPTH+1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous: invalidate all entries (mispredict/exception)
disp_valid  in  1  dispatch request
disp_ready  out  1  station can accept (not full)
disp_opcode  in  4  terminate opcode
disp_offset  in  8  signed PC-relative offset
disp_immediate  in  4  condition select / absolute low bits
disp_rob_entry  in  5  ROB index
disp_arch_dest_regs  in  8  two 4-bit arch destinations
disp_phys_dest_regs  in  10  two 5-bit phys destinations
disp_base_tag  in  5  phys tag of 16-bit base register
disp_base_rdy  in  1  base value already valid
disp_base_val  in  16  base value when rdy
disp_flag_tag  in  5  phys tag of flag register
disp_flag_rdy  in  1  flags already valid
disp_flag_val  in  8  flag value when rdy
wb_valid  in  1  writeback broadcast valid
wb_tag  in  5  broadcast phys tag
wb_value  in  16  broadcast value (flags use [7:0])
opcode  out  4  issued opcode
reg_base_val  out  16  issued base value
flag_vals  out  8  issued flags
offset  out  8  issued offset
immediate  out  4  issued immediate
instr_valid  out  1  an entry is issuable
instr_ready  in  1  terminate pipeline accepts
ROB_entries  out  5  issued ROB index
arch_dest_regs  out  8  issued arch dests
phys_dest_regs  out  10  issued phys dests
occupancy  out  clog2(DEPTH+1)  valid entry count

Behaviour:
- Storage: collapsing age-ordered queue; slot 0 oldest. Per slot: valid, all dispatch payload, base rdy/tag/val, flag rdy/tag/val.
- Reset (rst_n low, async): all valid bits 0; occupancy 0; instr_valid 0; disp_ready 1; all data outputs 0.
- disp_ready = (occupancy < DEPTH); it does not consider same-cycle issue.
- Enqueue on disp_valid & disp_ready; the entry is written at slot (occupancy - issued_this_cycle).
- Wakeup: each cycle, for every valid slot with base not rdy and base_tag == wb_tag while wb_valid, set base rdy and capture wb_value. Flags are handled the same way, capturing wb_value[7:0]. One wb can wake both operands of many slots.
- Enqueue bypass: if a disp source is not rdy but wb_valid & wb_tag matches that source, the entry is written already rdy with the wb value.
- Tag 0 is an ordinary tag; it has no special meaning.
- Ready slot = valid & base rdy & flag rdy, as seen in registered state. An operand woken in cycle N can issue no earlier than cycle N+1.
- Select: lowest-index ready slot. instr_valid = any slot ready. Outputs are combinational from the selected slot. When instr_valid = 0, all data outputs are 0.
- Issue when instr_valid & instr_ready. The selected slot is removed and higher slots shift down by one, preserving order and in-flight wakeups. The outputs of that slot must not change while instr_valid = 1 and instr_ready = 0, unless flush is asserted.
- Simultaneous enqueue + issue + wakeup in one cycle: all three take effect. Occupancy is unchanged, and a shifted slot keeps any wakeup applied that cycle.
- flush: next state is empty (occupancy 0), even if disp or issue fire that cycle; a dispatch in the flush cycle is dropped. instr_valid still reflects pre-flush state during the flush cycle. The downstream stage ignores any issue in that cycle.
- Async reset mid-operation: immediate return to reset state. No entry survives.
- Occupancy never exceeds DEPTH or underflows. Enqueue when full is impossible because disp_ready = 0.

Test Plan:
- Reset, then dispatch op (opcode 4'h1, base rdy 16'h1234, flags rdy 8'h05, rob 5'd7) with instr_ready=1 -> next cycle instr_valid=1, reg_base_val=16'h1234, ROB_entries=7; following cycle occupancy 0.
- Dispatch with base tag 5'd9 not rdy, then wb_valid, tag 9, value 16'hBEEF two cycles later -> instr_valid rises the cycle after wb with reg_base_val=16'hBEEF; no earlier.
- Dispatch A (rob 1, waiting tag 3), then B (rob 2, rdy) -> B issues first. Wake tag 3 -> A issues with ROB_entries=1. Fill 4 entries -> disp_ready=0.
- Hold instr_ready=0 with 2 ready entries for 5 cycles -> outputs stable on oldest. Then instr_ready=1 -> entries issue in order on consecutive cycles.
- Same cycle: dispatch with base tag 6 not rdy while wb tag 6 = 16'h00A0 -> entry issues next cycle with reg_base_val=16'h00A0.
- Full station plus flush with disp_valid=1 -> occupancy 0, instr_valid=0 next cycle. Assert rst_n low mid-stream -> outputs 0 immediately.
